exu_fpu_wb_ctl: RTL

Downstream stage of the FPU execute control block. It captures each finished FPU result together with its destination register and exception status in a small in-order buffer, and drives the FP register-file write port with a valid/ready handshake. It also owns the fcsr register: it accrues fflags at writeback, services CSR reads and writes, and supplies the dynamic rounding mode (frm) back to the FPU issue side.

---
 rtl/exu_fpu_wb_ctl.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/exu_fpu_wb_ctl.sv
// -----------------------------------------------------------------------------
// exu_fpu_wb_ctl
//
// Writeback control for the FPU execute path.
//   * Buffers each finished FPU result ({rd, data, status}) in a small in-order
//     circular buffer and presents the head entry on the FP register-file write
//     port using a valid/ready handshake.
//   * Owns fcsr = {frm, fflags}. It accrues exception flags as results are
//     written back, serves CSR reads and writes, and drives frm back to the
//     issue side.
//
// Configuration macro: FPU_WB_BYPASS_EN
//   If this macro is defined, a result that finishes while the buffer is empty
//   goes straight to the write port in the same cycle. If the port is granted,
//   the result is never pushed into the buffer.
//   If it is undefined, every result goes through the buffer, and wb_* is
//   driven from registered state only.
//
// Parameters:
//   DEPTH - number of buffer entries (power of two, >= 2)
//   FLEN  - result data width
//   RD_W  - destination register address width
//
// Ports:
//   clk, rst           - clock; synchronous active-high reset
//   fpu_finish/result/status/rd - result coming from the FPU
//   flush_lower        - discard every buffered result
//   wb_valid/ready/addr/data    - FP register-file write port
//   buf_full           - buffer cannot accept a push (FPU issue stalls)
//   ovf_err            - sticky: a finish was dropped because the buffer was full
//   csr_wen/addr/wdata - CSR write strobe, address and data
//   csr_rdata          - CSR read data (combinational)
//   frm, fflags        - current fcsr fields
// -----------------------------------------------------------------------------
module exu_fpu_wb_ctl #(
    parameter int DEPTH = 2,
    parameter int FLEN  = 32,
    parameter int RD_W  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fpu_finish,
    input  logic [FLEN-1:0] fpu_result,
    input  logic [4:0]      fpu_status,
    input  logic [RD_W-1:0] fpu_rd,
    input  logic            flush_lower,
    input  logic            wb_ready,
    output logic            wb_valid,
    output logic [RD_W-1:0] wb_addr,
    output logic [FLEN-1:0] wb_data,
    output logic            buf_full,
    output logic            ovf_err,
    input  logic            csr_wen,
    input  logic [11:0]     csr_addr,
    input  logic [31:0]     csr_wdata,
    output logic [31:0]     csr_rdata,
    output logic [2:0]      frm,
    output logic [4:0]      fflags
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [11:0] CSR_FFLAGS = 12'h001;
    localparam logic [11:0] CSR_FRM    = 12'h002;
    localparam logic [11:0] CSR_FCSR   = 12'h003;

    typedef struct packed {
        logic [RD_W-1:0] rd;
        logic [FLEN-1:0] data;
        logic [4:0]      status;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic [4:0]         fflags_q, fflags_d;
    logic [2:0]         frm_q, frm_d;

    entry_t             head;
    entry_t             push_entry;
    logic               buf_valid;
    logic               full;
    logic               pop_buf;
    logic               push;
    logic               drop;
    logic               byp_hit;
    logic               byp_take;
    logic [4:0]         accrue;
    logic               wr_fflags;
    logic               wr_frm;
    logic               wr_fcsr;

    // ------------------------------------------------------------------
    // Buffer control and handshake
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: give every always_comb output a default value first, so that no path can leave it unassigned and infer a latch.
        head       = mem_q[rd_ptr_q];
        push_entry = '{rd: fpu_rd, data: fpu_result, status: fpu_status};
        buf_valid  = (count_q != '0);
        full       = (count_q == CNT_W'(DEPTH));
        pop_buf    = buf_valid & wb_ready;

`ifdef FPU_WB_BYPASS_EN
        // Bypass is only possible when nothing older is waiting, so FIFO order holds.
        byp_hit  = fpu_finish & ~flush_lower & ~buf_valid;
        byp_take = byp_hit & wb_ready;
`else
        byp_hit  = 1'b0;
        byp_take = 1'b0;
`endif

        // When a pop happens in the same cycle, the slot it frees can take a push even if the buffer is full.
        push = fpu_finish & ~flush_lower & (~full | pop_buf) & ~byp_take;
        drop = fpu_finish & ~flush_lower & full & ~pop_buf;

        // Only results that actually reach the register file contribute flags.
        accrue = 5'b0;
        if (pop_buf) begin
            accrue = head.status;
        end else if (byp_take) begin
            accrue = fpu_status;
        end

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_lower) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_buf) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop_buf})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end

        ovf_d = ovf_q | drop;
    end

    // ------------------------------------------------------------------
    // fcsr update
    // ------------------------------------------------------------------
    always_comb begin
        wr_fflags = csr_wen & (csr_addr == CSR_FFLAGS);
        wr_frm    = csr_wen & (csr_addr == CSR_FRM);
        wr_fcsr   = csr_wen & (csr_addr == CSR_FCSR);

        // OR the flags of the write that happens in this same cycle into the CSR write value, so no exception is lost.
        fflags_d = fflags_q;
        if (wr_fflags | wr_fcsr) begin
            fflags_d = csr_wdata[4:0];
        end
        fflags_d = fflags_d | accrue;

        frm_d = frm_q;
        if (wr_frm) begin
            frm_d = csr_wdata[2:0];
        end else if (wr_fcsr) begin
            frm_d = csr_wdata[7:5];
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every register samples the values from before the edge.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            fflags_q <= 5'b0;
            frm_q    <= 3'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            fflags_q <= fflags_d;
            frm_q    <= frm_d;
        end
    end

    // NOTE: the entry storage is not reset. An entry is read only when count says it is valid, and the outputs are gated on that.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        wb_valid = buf_valid | byp_hit;
        wb_addr  = '0;
        wb_data  = '0;
        if (buf_valid) begin
            wb_addr = head.rd;
            wb_data = head.data;
        end else if (byp_hit) begin
            wb_addr = fpu_rd;
            wb_data = fpu_result;
        end

        unique case (csr_addr)
            CSR_FFLAGS: csr_rdata = {27'b0, fflags_q};
            CSR_FRM:    csr_rdata = {29'b0, frm_q};
            CSR_FCSR:   csr_rdata = {24'b0, frm_q, fflags_q};
            default:    csr_rdata = 32'b0;
        endcase
    end

    assign buf_full = full;
    assign ovf_err  = ovf_q;
    assign frm      = frm_q;
    assign fflags   = fflags_q;

endmodule
